// File: rtl/fairy_arb_pkg.sv
// Shared types for the fairy SRAM arbiter: FSM states, owner tags and starvation counter sizing.
package fairy_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_t;

  // Bits needed to count 0..limit inclusive.
  function automatic int starve_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/fairy_arb_starve_guard.sv
// Counts data grants taken while a fetch waits; asserts force_inst once STARVE_LIMIT is reached.
module fairy_arb_starve_guard
  import fairy_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inst_req,
  input  logic i_inst_gnt,
  input  logic i_data_gnt,
  output logic o_force_inst
);

  localparam int CNT_W = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_inst_gnt || !i_inst_req) begin
      r_cnt <= '0;
    end else if (i_data_gnt && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_force_inst = (r_cnt == LIMIT);

endmodule

// File: rtl/fairy_sram_arbiter.sv
// Shares one variable-latency SRAM port between fetch and data requesters, one transaction at a time.
// Data has priority; define FAIRY_ARB_STARVE_EN to let a starved fetch win after STARVE_LIMIT data grants.
module fairy_sram_arbiter
  import fairy_arb_pkg::*;
`ifdef FAIRY_ARB_STARVE_EN
#(
  parameter int STARVE_LIMIT = 4
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arb_state_t r_state, w_state_nxt;
  arb_owner_t r_owner;
  logic        r_wr;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_drop;

  logic w_force_inst;
  logic w_pick_inst;
  logic w_gnt;
  logic w_resp;

`ifdef FAIRY_ARB_STARVE_EN
  fairy_arb_starve_guard #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_guard (
    .clk          (clk),
    .reset        (reset),
    .i_inst_req   (inst_req),
    .i_inst_gnt   (inst_gnt),
    .i_data_gnt   (data_gnt),
    .o_force_inst (w_force_inst)
  );
`else
  assign w_force_inst = 1'b0;
`endif

  assign w_pick_inst = inst_req && (!data_req || w_force_inst);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    w_resp      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (inst_req || data_req) begin
          w_gnt       = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_addr_ok) begin
          w_resp      = mem_data_ok;
          w_state_nxt = mem_data_ok ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_data_ok) begin
          w_resp      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= OWN_INST;
      r_wr    <= 1'b0;
      r_be    <= 4'h0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt) begin
        r_owner <= w_pick_inst ? OWN_INST : OWN_DATA;
        r_wr    <= w_pick_inst ? 1'b0 : data_wr;
        r_be    <= w_pick_inst ? 4'hF : data_be;
        r_addr  <= w_pick_inst ? inst_addr : data_addr;
        r_wdata <= w_pick_inst ? 32'h0 : data_wdata;
      end
    end
  end

  // A flushed fetch still finishes on the bus; only its response is swallowed.
  always_ff @(posedge clk) begin
    if (reset || w_resp) begin
      r_drop <= 1'b0;
    end else if (flush && (r_state != S_IDLE) && (r_owner == OWN_INST)) begin
      r_drop <= 1'b1;
    end
  end

  assign inst_gnt    = w_gnt && w_pick_inst;
  assign data_gnt    = w_gnt && !w_pick_inst;
  assign inst_rvalid = w_resp && (r_owner == OWN_INST) && !r_drop && !flush;
  assign data_rvalid = w_resp && (r_owner == OWN_DATA);
  assign inst_rdata  = mem_rdata;
  assign data_rdata  = mem_rdata;

  assign mem_req   = (r_state == S_REQ);
  assign mem_wr    = r_wr;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule
